// File: rtl/tm_display_pkg.sv
// Shared definitions for the seven-segment display arbiter.
package tm_display_pkg;

    localparam int unsigned w_tm_digit = 8;
    localparam int unsigned w_slot     = 3;

    // Segment byte, bit order hgfedcba (bit 0 = segment a).
    typedef logic [7:0] seg_t;

    localparam seg_t seg_f     = 8'h71;
    localparam seg_t seg_p     = 8'h73;
    localparam seg_t seg_g     = 8'h3D;
    localparam seg_t seg_a     = 8'h77;
    localparam seg_t seg_space = 8'h00;

    // One-hot digit select for a scan slot.
    function automatic logic [w_tm_digit-1:0] digit_onehot(input logic [w_slot-1:0] slot);
        return w_tm_digit'(1) << slot;
    endfunction

endpackage

// File: rtl/tm_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first valid requester at or
// after the priority pointer; the pointer moves past the winner only when
// the grant is actually taken.
module tm_rr_arbiter #(
    parameter int unsigned n_req = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [n_req-1:0] valid,
    input  logic             accept,
    output logic [n_req-1:0] grant_c
);

    localparam int unsigned ptr_w = (n_req > 1) ? $clog2(n_req) : 1;

    logic [ptr_w-1:0] ptr;
    logic [ptr_w-1:0] ptr_nxt;
    logic             found;
    int unsigned      idx;

    // Rotating priority search starting at the pointer.
    always_comb begin
        grant_c = '0;
        ptr_nxt = ptr;
        found   = 1'b0;
        idx     = 0;
        for (int unsigned k = 0; k < n_req; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= n_req) begin
                idx = idx - n_req;
            end
            if (!found && valid[ptr_w'(idx)]) begin
                found                = 1'b1;
                grant_c[ptr_w'(idx)] = 1'b1;
                ptr_nxt              = (idx == n_req - 1) ? '0 : ptr_w'(idx + 1);
            end
        end
    end

    // Pointer advances only on an accepted transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (accept) begin
            ptr <= ptr_nxt;
        end
    end

endmodule

// File: rtl/tm_display_arbiter.sv
// Multi-requester write port into an 8-digit seven-segment frame buffer
// with an LED register and a multiplexed digit scanner.
module tm_display_arbiter
    import tm_display_pkg::*;
#(
    parameter int unsigned clk_mhz = 27,
    parameter int unsigned n_req   = 4,
    parameter int unsigned scan_us = 1000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [n_req-1:0]   req_valid,
    output logic [n_req-1:0]   req_ready,
    input  logic [3*n_req-1:0] req_idx,
    input  logic [8*n_req-1:0] req_seg,
    input  logic [2*n_req-1:0] req_led,
    input  logic               clear,
    output logic [7:0]         hgfedcba,
    output logic [7:0]         digit,
    output logic [7:0]         ledr
);

    localparam int unsigned scan_div = clk_mhz * scan_us;
    localparam int unsigned cnt_w    = (scan_div > 1) ? $clog2(scan_div) : 1;

    logic [n_req-1:0]  grant_c;
    logic              xfer_c;
    logic [w_slot-1:0] w_idx;
    seg_t              w_seg;
    logic [1:0]        w_led;

    seg_t              fb [w_tm_digit];
    logic [w_slot-1:0] slot;
    logic [w_slot-1:0] slot_nxt;
    logic [cnt_w-1:0]  cnt;
    logic [cnt_w-1:0]  cnt_nxt;
    seg_t              seg_nxt;

    tm_rr_arbiter #(
        .n_req (n_req)
    ) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid   (req_valid),
        .accept  (xfer_c),
        .grant_c (grant_c)
    );

    // Grants are suppressed during reset and while the frame is being cleared.
    assign req_ready = grant_c & {n_req{rst_n & ~clear}};
    assign xfer_c    = |(req_valid & req_ready);

    // Select the payload of the granted requester.
    always_comb begin
        w_idx = '0;
        w_seg = '0;
        w_led = '0;
        for (int unsigned i = 0; i < n_req; i++) begin
            if (req_ready[i]) begin
                w_idx = req_idx[3*i +: 3];
                w_seg = req_seg[8*i +: 8];
                w_led = req_led[2*i +: 2];
            end
        end
    end

    // Frame buffer and LED register writes; clear takes precedence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < w_tm_digit; i++) begin
                fb[i] <= '0;
            end
            ledr <= '0;
        end else if (clear) begin
            for (int unsigned i = 0; i < w_tm_digit; i++) begin
                fb[i] <= '0;
            end
            ledr <= '0;
        end else if (xfer_c) begin
            fb[w_idx] <= w_seg;
            if (w_led[0]) begin
                ledr[w_idx] <= w_led[1];
            end
        end
    end

    // Next scan position and the segment byte it will show, including a
    // write landing on that slot this cycle so live updates need no wait.
    always_comb begin
        cnt_nxt  = cnt + cnt_w'(1);
        slot_nxt = slot;
        if (cnt == cnt_w'(scan_div - 1)) begin
            cnt_nxt  = '0;
            slot_nxt = slot + w_slot'(1);
        end
        if (clear) begin
            seg_nxt = '0;
        end else if (xfer_c && (w_idx == slot_nxt)) begin
            seg_nxt = w_seg;
        end else begin
            seg_nxt = fb[slot_nxt];
        end
    end

    // Scan divider, slot and registered display drive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            slot     <= '0;
            digit    <= 8'h01;
            hgfedcba <= 8'h00;
        end else begin
            cnt      <= cnt_nxt;
            slot     <= slot_nxt;
            digit    <= digit_onehot(slot_nxt);
            hgfedcba <= seg_nxt;
        end
    end

endmodule

// File: tb/tb_tm_display_arbiter.sv
// Directed bench for tm_display_arbiter with a 4-cycle scan slot.
module tb_tm_display_arbiter;

    localparam int unsigned n_req = 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [n_req-1:0]   req_valid;
    logic [n_req-1:0]   req_ready;
    logic [3*n_req-1:0] req_idx;
    logic [8*n_req-1:0] req_seg;
    logic [2*n_req-1:0] req_led;
    logic               clear;
    logic [7:0]         hgfedcba;
    logic [7:0]         digit;
    logic [7:0]         ledr;

    int          chk_n = 0;
    int          err_n = 0;
    int unsigned k;
    logic [7:0]  exp_fb [8];

    tm_display_arbiter #(
        .clk_mhz (1),
        .n_req   (n_req),
        .scan_us (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_idx   (req_idx),
        .req_seg   (req_seg),
        .req_led   (req_led),
        .clear     (clear),
        .hgfedcba  (hgfedcba),
        .digit     (digit),
        .ledr      (ledr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        chk_n++;
        assert (obs === exp) else begin
            err_n++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic check_rdy(input string tag, input logic [3:0] exp);
        check(tag, {4'b0, req_ready}, {4'b0, exp});
    endtask

    // Expected scan state after k edges since reset release.
    task automatic check_scan();
        int unsigned s;
        logic [7:0]  ed;
        s  = (k / 4) % 8;
        ed = 8'h01 << s;
        check("scan_digit", digit, ed);
        check("scan_seg", hgfedcba, exp_fb[s]);
    endtask

    task automatic step();
        @(posedge clk);
        k++;
        #1;
    endtask

    task automatic set_req(input int unsigned i, input logic [2:0] idx,
                           input logic [7:0] seg, input logic [1:0] led);
        req_idx[3*i +: 3] = idx;
        req_seg[8*i +: 8] = seg;
        req_led[2*i +: 2] = led;
    endtask

    task automatic zero_model();
        for (int i = 0; i < 8; i++) exp_fb[i] = 8'h00;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_idx   = '0;
        req_seg   = '0;
        req_led   = '0;
        clear     = 1'b0;
        k         = 0;
        zero_model();

        // Reset with requests pending: no grants, idle display.
        req_valid = 4'b1111;
        repeat (3) @(posedge clk);
        #1;
        check_rdy("rst_ready", 4'b0000);
        check("rst_digit", digit, 8'h01);
        check("rst_seg", hgfedcba, 8'h00);
        check("rst_ledr", ledr, 8'h00);

        req_valid = '0;
        rst_n     = 1'b1;
        k         = 0;
        #1;
        check_rdy("post_rst_ready", 4'b0000);
        check("post_rst_digit", digit, 8'h01);
        check("post_rst_seg", hgfedcba, 8'h00);
        check("post_rst_ledr", ledr, 8'h00);

        // Round robin with all requesters valid: 0,1,2,3,0,1,2,3.
        for (int i = 0; i < 4; i++) set_req(i, 3'(i), 8'hA0 + 8'(i), 2'b00);
        req_valid = 4'b1111;
        #1;
        for (int c = 0; c < 8; c++) begin
            check_rdy("rr_order", 4'b0001 << (c % 4));
            step();
        end
        for (int i = 0; i < 4; i++) exp_fb[i] = 8'hA0 + 8'(i);
        check_scan();

        // Sparse valids: skip idle requesters and wrap 3 -> 0.
        req_valid = 4'b0101;
        #1;
        check_rdy("rr_sparse0", 4'b0001);
        step();
        check_rdy("rr_sparse2", 4'b0100);
        step();
        check_rdy("rr_wrap", 4'b0001);
        step();
        req_valid = '0;

        // Preload 0x11..0x88 through requester 1 (k = 11 .. 19).
        for (int j = 0; j < 8; j++) begin
            set_req(1, 3'(j), 8'(17 * (j + 1)), 2'b00);
            req_valid = 4'b0010;
            #1;
            check_rdy("preload_ready", 4'b0010);
            step();
            exp_fb[j] = 8'(17 * (j + 1));
            check_scan();
        end
        req_valid = '0;

        // Free-running scan, each slot held 4 cycles.
        for (int c = 0; c < 40; c++) begin
            step();
            check_scan();
        end
        while (k < 64) begin
            step();
            check_scan();
        end

        // Live update of slot 0 while it is being scanned.
        set_req(2, 3'd0, 8'h8E, 2'b00);
        req_valid = 4'b0100;
        #1;
        check_rdy("live_ready", 4'b0100);
        step();
        exp_fb[0] = 8'h8E;
        check("live_seg", hgfedcba, 8'h8E);
        check("live_digit", digit, 8'h01);
        req_valid = '0;

        // Clear colliding with a request: no grant, frame blanked.
        clear = 1'b1;
        set_req(1, 3'd5, 8'h5A, 2'b11);
        req_valid = 4'b0010;
        #1;
        check_rdy("clr_ready", 4'b0000);
        step();
        clear = 1'b0;
        zero_model();
        check("clr_seg", hgfedcba, 8'h00);
        check("clr_ledr", ledr, 8'h00);
        check_scan();
        #1;
        check_rdy("clr_retry_ready", 4'b0010);
        step();
        exp_fb[5] = 8'h5A;
        check("clr_retry_ledr", ledr, 8'h20);
        check_scan();
        req_valid = '0;

        // LED writes: enable/value bits.
        clear = 1'b1;
        #1;
        step();
        clear = 1'b0;
        zero_model();
        check("led_clr", ledr, 8'h00);

        set_req(0, 3'd3, 8'h33, 2'b11);
        req_valid = 4'b0001;
        #1;
        check_rdy("led_ready0", 4'b0001);
        step();
        exp_fb[3] = 8'h33;
        check("led_slot3", ledr, 8'h08);
        check_scan();

        set_req(3, 3'd5, 8'h55, 2'b11);
        req_valid = 4'b1000;
        #1;
        check_rdy("led_ready3", 4'b1000);
        step();
        exp_fb[5] = 8'h55;
        check("led_slot5", ledr, 8'h28);
        check_scan();

        set_req(1, 3'd3, 8'h77, 2'b10);
        req_valid = 4'b0010;
        #1;
        check_rdy("led_ready1", 4'b0010);
        step();
        exp_fb[3] = 8'h77;
        check("led_no_en", ledr, 8'h28);
        check_scan();

        set_req(2, 3'd5, 8'h66, 2'b01);
        req_valid = 4'b0100;
        #1;
        check_rdy("led_ready2", 4'b0100);
        step();
        exp_fb[5] = 8'h66;
        check("led_off5", ledr, 8'h08);
        check_scan();
        req_valid = '0;

        // Reset in the middle of a granted transfer.
        set_req(0, 3'd7, 8'hEE, 2'b11);
        req_valid = 4'b0001;
        #1;
        check_rdy("mid_ready", 4'b0001);
        rst_n = 1'b0;
        #1;
        check_rdy("mid_rst_ready", 4'b0000);
        check("mid_rst_digit", digit, 8'h01);
        check("mid_rst_seg", hgfedcba, 8'h00);
        check("mid_rst_ledr", ledr, 8'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        k     = 0;
        zero_model();
        #1;
        check_rdy("first_grant", 4'b0001);
        step();
        exp_fb[7] = 8'hEE;
        check("first_ledr", ledr, 8'h80);
        check_scan();
        req_valid = '0;
        while (k < 29) begin
            step();
            check_scan();
        end

        $display("Simulation finished: %0d checks, %0d errors", chk_n, err_n);
        $finish;
    end

endmodule

// File: doc/tm_display_arbiter.md
TM_DISPLAY_ARBITER -- requirements
Module: tm_display_arbiter

Interface
REQ-001 Parameter clk_mhz, default 27: system clock frequency in MHz.
REQ-002 Parameter n_req, default 4, range 2..8: number of display-write requesters.
REQ-003 Parameter scan_us, default 1000: dwell time of one digit slot in microseconds; scan_div = clk_mhz*scan_us clock cycles.
REQ-004 clk  in  1  single system clock; all state on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 req_valid  in  n_req  requester i holds a write.
REQ-007 req_ready  out  n_req  grant; a transfer occurs when valid[i] and ready[i] are both high.
REQ-008 req_idx  in  3*n_req  target digit slot 0..7, per requester.
REQ-009 req_seg  in  8*n_req  hgfedcba segment pattern, per requester.
REQ-010 req_led  in  2*n_req  bit0 = LED write enable; bit1 = LED value for slot req_idx.
REQ-011 clear  in  1  one-cycle pulse that blanks the whole frame.
REQ-012 hgfedcba  out  8  segments of the currently scanned slot, registered.
REQ-013 digit  out  8  one-hot digit select, registered.
REQ-014 ledr  out  8  LED frame, registered.

Function
REQ-015 The block SHALL keep a frame buffer of 8 segment bytes and one 8-bit LED register.
REQ-016 At most one ready bit SHALL be high per cycle; ready[i] is combinational from req_valid and the priority pointer.
REQ-017 Arbitration SHALL be round-robin: the winner is the first valid index at or after the pointer, wrapping n_req-1 -> 0.
REQ-018 After an accepted transfer by requester g, the pointer SHALL become (g+1) mod n_req; with no transfer it SHALL hold.
REQ-019 An accepted write SHALL update fb[req_idx] (and ledr[req_idx] if bit0 set) on the same clock edge and be visible on outputs from the next cycle.
REQ-020 Requesters SHALL hold valid and data stable until accepted; the block SHALL not drop a pending request.
REQ-021 Writes to the same slot in successive cycles: the last accepted write SHALL win.
REQ-022 clear high SHALL zero all 8 segment bytes and ledr on that edge, force all ready low in that cycle, and leave the pointer unchanged.
REQ-023 A scan divider SHALL count 0..scan_div-1; at terminal count it wraps to 0 and slot advances by 1, wrapping 7 -> 0.
REQ-024 digit SHALL equal 1 << slot; hgfedcba SHALL equal fb[slot], both registered so they change on the same edge.
REQ-025 A write to the currently scanned slot SHALL appear on hgfedcba one cycle after acceptance, without waiting for the next slot.

Reset
REQ-026 While rst_n is low: fb and ledr = 0, hgfedcba = 8'h00, digit = 8'b0000_0001, slot = 0, divider = 0, pointer = 0, all req_ready = 0.
REQ-027 Reset asserted mid-transfer SHALL discard the transfer; the first grant is possible in the first cycle after rst_n rises.

Structure
REQ-028 Shared package tm_display_pkg SHALL hold w_tm_digit = 8, the 8-bit segment typedef, and the seven-segment letter encodings (F, P, G, A, space).
REQ-029 Round-robin arbitration SHALL live in sub-module tm_rr_arbiter (inputs valid and transfer-accepted, outputs one-hot grant), instantiated once.

Verification
REQ-030 Reset: after rst_n rises, digit = 8'h01, hgfedcba = 8'h00, ledr = 8'h00, req_ready = 0.
REQ-031 Round-robin: n_req = 4, all valid held for 8 cycles -> grant order 0,1,2,3,0,1,2,3.
REQ-032 Scan: scan_div = 4 (test override), fb preloaded 0x11..0x88 -> digit sequence 01,02,...,80,01, each held 4 cycles, hgfedcba matching.
REQ-033 Live update: requester 2 writes slot 0 = 8'h8E while slot 0 is scanned -> hgfedcba = 8'h8E on the next cycle.
REQ-034 Clear collision: clear and req_valid[1] in the same cycle -> ready[1] low, frame all zero; write accepted in the following cycle.
REQ-035 LED: writes with req_led = 2'b11 to slots 3 and 5 -> ledr = 8'b0010_1000; a write with req_led = 2'b10 leaves ledr unchanged.
